alarm_bank: RTL and testbench

//  Multi-channel alarm generator. Each channel compares the free-running system

---
 rtl/alarm_pkg.sv | 15 +
 rtl/alarm_channel.sv | 82 ++++++++
 rtl/alarm_bank.sv | 59 +++++
 tb/tb_alarm_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared mode codes and channel FSM states for the alarm bank.
package alarm_pkg;

    localparam logic [1:0] MODE_LEVEL    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: compare/reload registers, mode FSM, sticky status and overrun.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] counter_i,
    input  logic             cfg_we_i,
    input  logic             cfg_en_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_alarm_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             irq_clr_i,
    output logic             alarm_o,
    output logic             status_o,
    output logic             overrun_o,
    output logic             armed_o
);

    state_e           state;
    logic [CNT_W-1:0] cmp;
    logic [CNT_W-1:0] period;
    logic [1:0]       mode;
    logic             match;
    logic             fire;

    assign match   = (state == ST_ARMED) && (counter_i == cmp);
    // A config write in the match cycle suppresses the fire entirely.
    assign fire    = match && !cfg_we_i;
    assign armed_o = (state == ST_ARMED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cmp       <= '0;
            period    <= '0;
            mode      <= MODE_LEVEL;
            alarm_o   <= 1'b0;
            status_o  <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            alarm_o <= 1'b0;
            if (cfg_we_i) begin
                if (cfg_en_i && (cfg_mode_i != MODE_RSVD)) begin
                    cmp    <= cfg_alarm_i;
                    period <= cfg_period_i;
                    mode   <= cfg_mode_i;
                    state  <= ST_ARMED;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (fire) begin
                alarm_o <= 1'b1;
                if (mode == MODE_ONESHOT) begin
                    state <= ST_DONE;
                end else if (mode == MODE_PERIODIC) begin
                    if (period == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cmp <= cmp + period;
                    end
                end
            end

            // A same-cycle clear counts this fire as fresh, so overrun drops.
            if (fire) begin
                status_o <= 1'b1;
                if (irq_clr_i) begin
                    overrun_o <= 1'b0;
                end else if ((mode != MODE_LEVEL) && status_o) begin
                    overrun_o <= 1'b1;
                end
            end else if (irq_clr_i) begin
                status_o  <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm generator with per-channel config decode and a masked interrupt.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  counter_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic              cfg_en_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [CNT_W-1:0]  cfg_alarm_i,
    input  logic [CNT_W-1:0]  cfg_period_i,
    input  logic [NUM_CH-1:0] irq_mask_i,
    input  logic [NUM_CH-1:0] irq_clr_i,
    output logic [NUM_CH-1:0] alarm_o,
    output logic [NUM_CH-1:0] status_o,
    output logic [NUM_CH-1:0] overrun_o,
    output logic [NUM_CH-1:0] armed_o,
    output logic              irq_o
);

    // Channel numbers at or beyond NUM_CH never decode, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;
        assign we = cfg_we_i && (cfg_ch_i == CH_W'(i));

        alarm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .counter_i    (counter_i),
            .cfg_we_i     (we),
            .cfg_en_i     (cfg_en_i),
            .cfg_mode_i   (cfg_mode_i),
            .cfg_alarm_i  (cfg_alarm_i),
            .cfg_period_i (cfg_period_i),
            .irq_clr_i    (irq_clr_i[i]),
            .alarm_o      (alarm_o[i]),
            .status_o     (status_o[i]),
            .overrun_o    (overrun_o[i]),
            .armed_o      (armed_o[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(status_o & irq_mask_i);
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expected pulses queued by stimulus, checked by a monitor.
module tb_alarm_bank;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] counter_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_ch_i;
    logic        cfg_en_i;
    logic [1:0]  cfg_mode_i;
    logic [31:0] cfg_alarm_i;
    logic [31:0] cfg_period_i;
    logic [3:0]  irq_mask_i;
    logic [3:0]  irq_clr_i;
    logic [3:0]  alarm_o;
    logic [3:0]  status_o;
    logic [3:0]  overrun_o;
    logic [3:0]  armed_o;
    logic        irq_o;

    alarm_bank #(.NUM_CH(4), .CNT_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .counter_i    (counter_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_ch_i     (cfg_ch_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_alarm_i  (cfg_alarm_i),
        .cfg_period_i (cfg_period_i),
        .irq_mask_i   (irq_mask_i),
        .irq_clr_i    (irq_clr_i),
        .alarm_o      (alarm_o),
        .status_o     (status_o),
        .overrun_o    (overrun_o),
        .armed_o      (armed_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       cyc;
        logic [3:0] alarm;
        logic [3:0] status;
        logic [3:0] overrun;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every alarm pulse must match the next queued expectation.
    always @(negedge clk_i) begin
        if (alarm_o !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_alarm: got %b expected none (cycle %0d)", alarm_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alarm_cycle", cyc, e.cyc);
                chk("alarm_vec", {28'd0, alarm_o}, {28'd0, e.alarm});
                chk("status_vec", {28'd0, status_o}, {28'd0, e.status});
                chk("overrun_vec", {28'd0, overrun_o}, {28'd0, e.overrun});
            end
        end
    end

    task automatic tick(input logic [31:0] c);
        counter_i = c;
        @(posedge clk_i);
        #1;
    endtask

    // Expect a pulse produced by the edge that samples the next tick.
    task automatic expect_pulse(input logic [3:0] a, input logic [3:0] s, input logic [3:0] o);
        exp_t e;
        e.cyc = cyc + 1;
        e.alarm = a;
        e.status = s;
        e.overrun = o;
        exp_q.push_back(e);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic en, input logic [1:0] mode,
                       input logic [31:0] alarm, input logic [31:0] period,
                       input logic [31:0] c);
        cfg_we_i     = 1'b1;
        cfg_ch_i     = ch;
        cfg_en_i     = en;
        cfg_mode_i   = mode;
        cfg_alarm_i  = alarm;
        cfg_period_i = period;
        tick(c);
        cfg_we_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; counter_i = '0; cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_en_i = 1'b0;
        cfg_mode_i = '0; cfg_alarm_i = '0; cfg_period_i = '0; irq_mask_i = '0; irq_clr_i = '0;

        // Reset held two cycles with the counter running
        tick(32'd0);
        tick(32'd1);
        chk("reset_outputs", {15'd0, alarm_o, status_o, overrun_o, armed_o, irq_o}, 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) tick(32'(i));
        chk("idle_armed", {28'd0, armed_o}, 32'd0);

        // ONESHOT on ch0 at 100
        irq_mask_i = 4'b0001;
        cfg(2'd0, 1'b1, 2'b01, 32'd100, 32'd0, 32'd10);
        chk("oneshot_armed", {28'd0, armed_o}, 32'h1);
        tick(32'd98);
        tick(32'd99);
        expect_pulse(4'b0001, 4'b0001, 4'b0000);
        tick(32'd100);
        tick(32'd101);
        chk("oneshot_irq", {31'd0, irq_o}, 32'd1);
        chk("oneshot_done", {28'd0, armed_o}, 32'd0);
        tick(32'd99);
        tick(32'd100);
        tick(32'd101);
        irq_clr_i = 4'b0001;
        tick(32'd102);
        irq_clr_i = 4'b0000;
        chk("oneshot_cleared", {28'd0, status_o}, 32'd0);

        // PERIODIC wrap on ch1
        cfg(2'd1, 1'b1, 2'b10, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFE0);
        expect_pulse(4'b0010, 4'b0010, 4'b0000);
        tick(32'hFFFF_FFF0);
        expect_pulse(4'b0010, 4'b0010, 4'b0010);
        tick(32'h0000_0010);
        tick(32'h0000_0020);
        expect_pulse(4'b0010, 4'b0010, 4'b0010);
        tick(32'h0000_0030);
        irq_clr_i = 4'b0010;
        cfg(2'd1, 1'b0, 2'b10, 32'd0, 32'd0, 32'h31);
        irq_clr_i = 4'b0000;
        chk("periodic_disarm", {28'd0, armed_o}, 32'd0);
        chk("periodic_clear", {28'd0, status_o | overrun_o}, 32'd0);
        chk("masked_irq_low", {31'd0, irq_o}, 32'd0);

        // LEVEL on ch2, counter held at 5
        cfg(2'd2, 1'b1, 2'b00, 32'd5, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expect_pulse(4'b0100, 4'b0100, 4'b0000);
            tick(32'd5);
        end
        irq_clr_i = 4'b0100;
        cfg(2'd2, 1'b0, 2'b00, 32'd5, 32'd0, 32'd5);
        irq_clr_i = 4'b0000;
        chk("level_off_alarm", {28'd0, alarm_o}, 32'd0);
        chk("level_off_armed", {28'd0, armed_o}, 32'd0);

        // Collision on ch3: rewrite 50 -> 60 in the match cycle
        cfg(2'd3, 1'b1, 2'b01, 32'd50, 32'd0, 32'd0);
        cfg(2'd3, 1'b1, 2'b10, 32'd60, 32'd10, 32'd50);
        tick(32'd51);
        irq_clr_i = 4'b1000;
        expect_pulse(4'b1000, 4'b1000, 4'b0000);
        tick(32'd60);
        irq_clr_i = 4'b0000;
        expect_pulse(4'b1000, 4'b1000, 4'b1000);
        tick(32'd70);
        irq_clr_i = 4'b1000;
        expect_pulse(4'b1000, 4'b1000, 4'b0000);
        tick(32'd80);
        cfg(2'd3, 1'b0, 2'b00, 32'd0, 32'd0, 32'd81);
        irq_clr_i = 4'b0000;
        chk("collision_cleared", {28'd0, status_o}, 32'd0);

        // Independence and masking: ch0 and ch3 fire together
        cfg(2'd0, 1'b1, 2'b01, 32'd200, 32'd0, 32'd0);
        cfg(2'd3, 1'b1, 2'b01, 32'd200, 32'd0, 32'd0);
        chk("both_armed", {28'd0, armed_o}, 32'h9);
        expect_pulse(4'b1001, 4'b1001, 4'b0000);
        tick(32'd200);
        tick(32'd201);
        chk("both_irq", {31'd0, irq_o}, 32'd1);
        irq_clr_i = 4'b0001;
        tick(32'd202);
        irq_clr_i = 4'b0000;
        tick(32'd203);
        chk("mask_irq_drop", {31'd0, irq_o}, 32'd0);
        chk("mask_status", {28'd0, status_o}, 32'h8);

        // Reset during a match drops the pending pulse
        cfg(2'd1, 1'b1, 2'b01, 32'd300, 32'd0, 32'd0);
        rst_i = 1'b1;
        tick(32'd300);
        rst_i = 1'b0;
        chk("midreset_outputs", {15'd0, alarm_o, status_o, overrun_o, armed_o, irq_o}, 32'd0);
        tick(32'd300);
        tick(32'd301);
        tick(32'd302);

        chk("pending_pulses", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
